branch_predict_unit: RTL and testbench

BRANCH_PREDICT_UNIT -- requirements
Module: branch_predict_unit

---
 rtl/branch_predict_unit_pkg.sv | 43 ++++
 rtl/branch_predict_unit_cond_eval.sv | 39 +++
 rtl/branch_predict_unit.sv | 124 ++++++++++++
 tb/tb_branch_predict_unit.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/branch_predict_unit_pkg.sv
// Shared constants for the branch predictor: branch op class, condition codes,
// flag bit positions and 2-bit saturating counter encodings.
package branch_predict_unit_pkg;

  localparam logic [1:0] BR_OP_TYPE = 2'b11;

  typedef enum logic [3:0] {
    CC_AL = 4'd0,
    CC_EQ = 4'd1,
    CC_NE = 4'd2,
    CC_LE = 4'd3,
    CC_GT = 4'd4,
    CC_MI = 4'd5,
    CC_PL = 4'd6,
    CC_CS = 4'd7,
    CC_CC = 4'd8,
    CC_VS = 4'd9,
    CC_VC = 4'd10
  } cond_code_e;

  localparam logic [3:0] CC_LAST = 4'd10;

  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_C = 2;
  localparam int FLAG_V = 3;

  localparam logic [1:0] PHT_SNT = 2'b00;
  localparam logic [1:0] PHT_WNT = 2'b01;
  localparam logic [1:0] PHT_WT  = 2'b10;
  localparam logic [1:0] PHT_ST  = 2'b11;

  function automatic logic [1:0] pht_next(input logic [1:0] cur, input logic tk);
    logic [1:0] nxt;
    if (tk) begin
      nxt = (cur == PHT_ST) ? PHT_ST : cur + 2'b01;
    end else begin
      nxt = (cur == PHT_SNT) ? PHT_SNT : cur - 2'b01;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/branch_predict_unit_cond_eval.sv
// Combinational branch condition evaluation from op class, condition code and flags.
module branch_cond_eval
  import branch_predict_unit_pkg::*;
(
  input  logic [1:0] op_type,
  input  logic [3:0] op_code,
  input  logic [3:0] flags,
  output logic       cond_taken
);

  logic z_s, n_s, c_s, v_s, cond_s;

  assign z_s = flags[FLAG_Z];
  assign n_s = flags[FLAG_N];
  assign c_s = flags[FLAG_C];
  assign v_s = flags[FLAG_V];

  // Decode condition code; undefined codes never take.
  always_comb begin
    cond_s = 1'b0;
    case (op_code)
      CC_AL:   cond_s = 1'b1;
      CC_EQ:   cond_s = z_s;
      CC_NE:   cond_s = ~z_s;
      CC_LE:   cond_s = z_s | n_s;
      CC_GT:   cond_s = ~z_s & ~n_s;
      CC_MI:   cond_s = n_s;
      CC_PL:   cond_s = ~n_s;
      CC_CS:   cond_s = c_s;
      CC_CC:   cond_s = ~c_s;
      CC_VS:   cond_s = v_s;
      CC_VC:   cond_s = ~v_s;
      default: cond_s = 1'b0;
    endcase
  end

  assign cond_taken = (op_type == BR_OP_TYPE) & cond_s;

endmodule

// File: rtl/branch_predict_unit.sv
// Bimodal branch predictor: 2-bit counter PHT, one-cycle resolve pipeline,
// redirect generation and saturating branch/mispredict statistics.
module branch_predict_unit
  import branch_predict_unit_pkg::*;
#(
  parameter int PC_WIDTH    = 32,
  parameter int PHT_ENTRIES = 64,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [PC_WIDTH-1:0]  pred_pc,
  output logic                 pred_taken,
  input  logic                 res_valid,
  input  logic [PC_WIDTH-1:0]  res_pc,
  input  logic [1:0]           res_op_type,
  input  logic [3:0]           res_op_code,
  input  logic [3:0]           res_flags,
  input  logic                 res_pred_taken,
  input  logic [PC_WIDTH-1:0]  res_target,
  input  logic [PC_WIDTH-1:0]  res_fallthrough,
  input  logic                 stat_clear,
  output logic                 taken,
  output logic                 mispredict,
  output logic [PC_WIDTH-1:0]  redirect_pc,
  output logic [CNT_WIDTH-1:0] branch_count,
  output logic [CNT_WIDTH-1:0] mispredict_count
);

  localparam int IDX_W = $clog2(PHT_ENTRIES);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic [1:0]           pht_q [PHT_ENTRIES];
  logic [1:0]           pht_d [PHT_ENTRIES];
  logic                 taken_q, taken_d;
  logic                 mispredict_q, mispredict_d;
  logic [PC_WIDTH-1:0]  redirect_pc_q, redirect_pc_d;
  logic [CNT_WIDTH-1:0] branch_count_q, branch_count_d;
  logic [CNT_WIDTH-1:0] mispredict_count_q, mispredict_count_d;

  logic [IDX_W-1:0] pred_idx_s, res_idx_s;
  logic             cond_taken_s, pht_upd_s, misp_s;
  logic             unused_pc_bits_s;

  branch_cond_eval u_cond_eval (
    .op_type    (res_op_type),
    .op_code    (res_op_code),
    .flags      (res_flags),
    .cond_taken (cond_taken_s)
  );

  assign pred_idx_s = pred_pc[IDX_W+1:2];
  assign res_idx_s  = res_pc[IDX_W+1:2];
  assign pred_taken = pht_q[pred_idx_s][1];
  assign unused_pc_bits_s = ^{pred_pc[PC_WIDTH-1:IDX_W+2], pred_pc[1:0],
                              res_pc[PC_WIDTH-1:IDX_W+2], res_pc[1:0]};

  // Undefined condition codes resolve not-taken but must not train the PHT.
  assign pht_upd_s = res_valid & (res_op_type == BR_OP_TYPE) & (res_op_code <= CC_LAST);
  assign misp_s    = res_valid & (cond_taken_s != res_pred_taken);

  // Next-state for PHT, resolve outputs and statistics.
  always_comb begin
    pht_d = pht_q;
    if (pht_upd_s) begin
      pht_d[res_idx_s] = pht_next(pht_q[res_idx_s], cond_taken_s);
    end else begin
      pht_d = pht_q;
    end

    taken_d      = res_valid & cond_taken_s;
    mispredict_d = misp_s;
    if (res_valid) begin
      redirect_pc_d = cond_taken_s ? res_target : res_fallthrough;
    end else begin
      redirect_pc_d = redirect_pc_q;
    end

    if (stat_clear) begin
      branch_count_d     = {CNT_WIDTH{1'b0}};
      mispredict_count_d = {CNT_WIDTH{1'b0}};
    end else begin
      if (pht_upd_s && (branch_count_q != CNT_MAX)) begin
        branch_count_d = branch_count_q + CNT_ONE;
      end else begin
        branch_count_d = branch_count_q;
      end
      if (misp_s && (mispredict_count_q != CNT_MAX)) begin
        mispredict_count_d = mispredict_count_q + CNT_ONE;
      end else begin
        mispredict_count_d = mispredict_count_q;
      end
    end
  end

  // State registers; PHT resets to weakly not-taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < PHT_ENTRIES; i++) begin
        pht_q[i] <= PHT_WNT;
      end
      taken_q            <= 1'b0;
      mispredict_q       <= 1'b0;
      redirect_pc_q      <= {PC_WIDTH{1'b0}};
      branch_count_q     <= {CNT_WIDTH{1'b0}};
      mispredict_count_q <= {CNT_WIDTH{1'b0}};
    end else begin
      pht_q              <= pht_d;
      taken_q            <= taken_d;
      mispredict_q       <= mispredict_d;
      redirect_pc_q      <= redirect_pc_d;
      branch_count_q     <= branch_count_d;
      mispredict_count_q <= mispredict_count_d;
    end
  end

  assign taken            = taken_q;
  assign mispredict       = mispredict_q;
  assign redirect_pc      = redirect_pc_q;
  assign branch_count     = branch_count_q;
  assign mispredict_count = mispredict_count_q;

endmodule

// File: tb/tb_branch_predict_unit.sv
// Self-checking bench: condition-code vector table plus hand sequences for
// training, saturation, stat_clear and asynchronous reset, with a scoreboard queue.
module tb_branch_predict_unit;

  localparam int PCW = 32;
  localparam int CW  = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [PCW-1:0] pred_pc;
  logic           pred_taken;
  logic           res_valid;
  logic [PCW-1:0] res_pc;
  logic [1:0]     res_op_type;
  logic [3:0]     res_op_code;
  logic [3:0]     res_flags;
  logic           res_pred_taken;
  logic [PCW-1:0] res_target;
  logic [PCW-1:0] res_fallthrough;
  logic           stat_clear;
  logic           taken;
  logic           mispredict;
  logic [PCW-1:0] redirect_pc;
  logic [CW-1:0]  branch_count;
  logic [CW-1:0]  mispredict_count;

  branch_predict_unit #(.PC_WIDTH(PCW), .PHT_ENTRIES(64), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .pred_pc(pred_pc), .pred_taken(pred_taken),
    .res_valid(res_valid), .res_pc(res_pc), .res_op_type(res_op_type),
    .res_op_code(res_op_code), .res_flags(res_flags), .res_pred_taken(res_pred_taken),
    .res_target(res_target), .res_fallthrough(res_fallthrough), .stat_clear(stat_clear),
    .taken(taken), .mispredict(mispredict), .redirect_pc(redirect_pc),
    .branch_count(branch_count), .mispredict_count(mispredict_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [1:0] ot;
    logic [3:0] oc;
    logic [3:0] fl;
    logic       pr;
    logic       et;
  } vec_t;

  typedef struct {
    logic           tk;
    logic           mp;
    logic [PCW-1:0] rd;
    int             bc;
    int             mc;
  } exp_t;

  exp_t           sb_q[$];
  int             pht_m[64];
  int             bcnt_m, mcnt_m;
  logic [PCW-1:0] redir_m;
  int             checks = 0;
  int             errors = 0;
  vec_t           tbl[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 64; i++) pht_m[i] = 1;
    bcnt_m = 0;
    mcnt_m = 0;
    redir_m = '0;
    sb_q.delete();
  endtask

  // Drive one resolve cycle, predict into the scoreboard, then compare after the edge.
  task automatic do_res(input logic v, input logic [1:0] ot, input logic [3:0] oc,
                        input logic [3:0] fl, input logic pr, input logic [PCW-1:0] pc,
                        input logic [PCW-1:0] tgt, input logic [PCW-1:0] ft,
                        input logic sc, input logic et);
    exp_t e;
    logic upd, mp;
    int   idx;
    res_valid = v; res_op_type = ot; res_op_code = oc; res_flags = fl;
    res_pred_taken = pr; res_pc = pc; res_target = tgt; res_fallthrough = ft;
    stat_clear = sc;
    upd = v && (ot == 2'b11) && (oc <= 4'd10);
    mp  = v && (et != pr);
    idx = int'(pc[7:2]);
    if (v) redir_m = et ? tgt : ft;
    if (upd) begin
      if (et) pht_m[idx] = (pht_m[idx] == 3) ? 3 : pht_m[idx] + 1;
      else    pht_m[idx] = (pht_m[idx] == 0) ? 0 : pht_m[idx] - 1;
    end
    if (sc) begin
      bcnt_m = 0;
      mcnt_m = 0;
    end else begin
      if (upd && bcnt_m < 15) bcnt_m++;
      if (mp && mcnt_m < 15) mcnt_m++;
    end
    e.tk = v && et; e.mp = mp; e.rd = redir_m; e.bc = bcnt_m; e.mc = mcnt_m;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL scoreboard: got empty queue expected entry");
    end else begin
      e = sb_q.pop_front();
      check("taken", {31'd0, taken}, {31'd0, e.tk});
      check("mispredict", {31'd0, mispredict}, {31'd0, e.mp});
      check("redirect_pc", redirect_pc, e.rd);
      check("branch_count", {28'd0, branch_count}, e.bc);
      check("mispredict_count", {28'd0, mispredict_count}, e.mc);
    end
    res_valid = 1'b0;
    stat_clear = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_pred(input string name, input logic [PCW-1:0] pc);
    pred_pc = pc;
    #1;
    check(name, {31'd0, pred_taken}, {31'd0, pht_m[int'(pc[7:2])] >= 2});
  endtask

  initial begin
    tbl[0]  = '{1'b1, 2'b11, 4'd0,  4'b0000, 1'b0, 1'b1};
    tbl[1]  = '{1'b1, 2'b11, 4'd1,  4'b0001, 1'b0, 1'b1};
    tbl[2]  = '{1'b1, 2'b11, 4'd1,  4'b0000, 1'b1, 1'b0};
    tbl[3]  = '{1'b1, 2'b11, 4'd2,  4'b0000, 1'b0, 1'b1};
    tbl[4]  = '{1'b1, 2'b11, 4'd3,  4'b0010, 1'b0, 1'b1};
    tbl[5]  = '{1'b1, 2'b11, 4'd4,  4'b0000, 1'b1, 1'b1};
    tbl[6]  = '{1'b1, 2'b11, 4'd4,  4'b0001, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 2'b11, 4'd5,  4'b0010, 1'b1, 1'b1};
    tbl[8]  = '{1'b1, 2'b11, 4'd6,  4'b0010, 1'b0, 1'b0};
    tbl[9]  = '{1'b1, 2'b11, 4'd7,  4'b0100, 1'b1, 1'b1};
    tbl[10] = '{1'b1, 2'b11, 4'd8,  4'b0100, 1'b0, 1'b0};
    tbl[11] = '{1'b1, 2'b11, 4'd9,  4'b1000, 1'b0, 1'b1};
    tbl[12] = '{1'b1, 2'b11, 4'd10, 4'b1000, 1'b0, 1'b0};
    tbl[13] = '{1'b1, 2'b11, 4'd11, 4'b1111, 1'b1, 1'b0};
    tbl[14] = '{1'b1, 2'b11, 4'd15, 4'b1111, 1'b0, 1'b0};
    tbl[15] = '{1'b1, 2'b01, 4'd0,  4'b0000, 1'b1, 1'b0};

    rst_n = 1'b0; pred_pc = '0; res_valid = 1'b0; res_pc = '0; res_op_type = 2'b00;
    res_op_code = 4'd0; res_flags = 4'd0; res_pred_taken = 1'b0; res_target = '0;
    res_fallthrough = '0; stat_clear = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Reset state and first trained branch.
    check("rst_taken", {31'd0, taken}, 32'd0);
    check("rst_redirect", redirect_pc, 32'd0);
    check("rst_counts", {24'd0, branch_count, mispredict_count}, 32'd0);
    check_pred("rst_pred_0x40", 32'h40);
    do_res(1'b1, 2'b11, 4'd1, 4'b0001, 1'b0, 32'h40, 32'h100, 32'h44, 1'b0, 1'b1);
    check_pred("pred_0x40_after1", 32'h40);
    do_res(1'b1, 2'b11, 4'd0, 4'b0000, 1'b1, 32'h40, 32'h100, 32'h44, 1'b0, 1'b1);
    do_res(1'b1, 2'b11, 4'd0, 4'b0000, 1'b1, 32'h40, 32'h100, 32'h44, 1'b0, 1'b1);
    check_pred("pred_0x40_strong", 32'h40);
    do_res(1'b1, 2'b11, 4'd2, 4'b0001, 1'b1, 32'h40, 32'h100, 32'h44, 1'b0, 1'b0);
    check_pred("pred_0x40_weak_t", 32'h40);
    do_res(1'b1, 2'b11, 4'd2, 4'b0001, 1'b1, 32'h40, 32'h100, 32'h44, 1'b0, 1'b0);
    check_pred("pred_0x40_weak_nt", 32'h40);

    // Non-branch mispredict, then an idle cycle that must hold redirect_pc.
    do_res(1'b1, 2'b00, 4'd0, 4'b0000, 1'b1, 32'h80, 32'h200, 32'h44, 1'b0, 1'b0);
    do_res(1'b0, 2'b11, 4'd0, 4'b0000, 1'b0, 32'h80, 32'h300, 32'h304, 1'b0, 1'b1);

    // Condition-code table.
    do_res(1'b0, 2'b00, 4'd0, 4'b0000, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
    for (int i = 0; i < 16; i++) begin
      do_res(tbl[i].v, tbl[i].ot, tbl[i].oc, tbl[i].fl, tbl[i].pr,
             32'h200 + 32'(i * 4), 32'h1000 + 32'(i * 16), 32'h204 + 32'(i * 4),
             1'b0, tbl[i].et);
      check_pred("tbl_pred", 32'h200 + 32'(i * 4));
    end

    // Counter saturation and clear-wins-over-increment.
    do_res(1'b0, 2'b00, 4'd0, 4'b0000, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
    for (int i = 0; i < 17; i++)
      do_res(1'b1, 2'b00, 4'd0, 4'b0000, 1'b1, 32'h60, 32'h0, 32'h64 + 32'(i), 1'b0, 1'b0);
    check("mcnt_saturated", {28'd0, mispredict_count}, 32'd15);
    do_res(1'b1, 2'b11, 4'd0, 4'b0000, 1'b0, 32'h60, 32'h500, 32'h64, 1'b1, 1'b1);

    // Asynchronous reset with a resolve in flight.
    do_res(1'b1, 2'b11, 4'd0, 4'b0000, 1'b0, 32'h40, 32'h700, 32'h44, 1'b0, 1'b1);
    res_valid = 1'b1; res_op_type = 2'b11; res_op_code = 4'd0; res_pred_taken = 1'b0;
    res_pc = 32'h40; res_target = 32'h800;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_taken", {31'd0, taken}, 32'd0);
    check("async_mispredict", {31'd0, mispredict}, 32'd0);
    check("async_redirect", redirect_pc, 32'd0);
    check("async_counts", {24'd0, branch_count, mispredict_count}, 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    check("inflight_dropped", {31'd0, taken}, 32'd0);
    @(negedge clk);
    res_valid = 1'b0;
    rst_n = 1'b1;
    check_pred("post_rst_pred_0x40", 32'h40);
    do_res(1'b1, 2'b11, 4'd1, 4'b0001, 1'b0, 32'h40, 32'h100, 32'h44, 1'b0, 1'b1);
    check_pred("post_rst_trained", 32'h40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
